// File: rtl/irq_arbiter.sv
// Interrupt request/enable registers with 68000 priority encoding.
// All state advances only on clk edges qualified by clk7_en.
module irq_arbiter (
    input  logic        clk,
    input  logic        clk7_en,
    input  logic        reset,
    input  logic        wr,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        txint,
    input  logic        rxint,
    input  logic        vblint,
    input  logic        blckint,
    input  logic        syncint,
    input  logic        int3,
    input  logic [3:0]  audint,
    input  logic        int2,
    input  logic        int6,
    output logic [2:0]  _ipl
);

    localparam logic [8:1] INTENAR_ADDR = 8'h0E;
    localparam logic [8:1] INTREQR_ADDR = 8'h0F;
    localparam logic [8:1] INTENA_ADDR  = 8'h4D;
    localparam logic [8:1] INTREQ_ADDR  = 8'h4E;

    logic [14:0] intena_reg, intena_next;
    logic [13:0] intreq_reg, intreq_next;
    logic        int2_reg, int6_reg;
    logic [2:0]  ipl_reg;
    logic [13:0] hw_set;
    logic [13:0] act;
    logic [2:0]  level;
    logic        ena_wr, req_wr;

    assign ena_wr = wr && (reg_address_in == INTENA_ADDR);
    assign req_wr = wr && (reg_address_in == INTREQ_ADDR);

    // CIA lines are levels, so only a rising edge may raise a request.
    assign hw_set[0]    = txint;
    assign hw_set[2:1]  = 2'b00;
    assign hw_set[3]    = int2 & ~int2_reg;
    assign hw_set[4]    = int3;
    assign hw_set[5]    = vblint;
    assign hw_set[6]    = blckint;
    assign hw_set[10:7] = audint;
    assign hw_set[11]   = rxint;
    assign hw_set[12]   = syncint;
    assign hw_set[13]   = int6 & ~int6_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_ena
            assign intena_next[gi] = (ena_wr && data_in[gi]) ? data_in[15] : intena_reg[gi];
        end
        // Hardware set is ORed last so it overrides a same-cycle software clear.
        for (gi = 0; gi < 14; gi++) begin : g_req
            assign intreq_next[gi] = hw_set[gi] |
                                     ((req_wr && data_in[gi]) ? data_in[15] : intreq_reg[gi]);
        end
    endgenerate

    assign act = intena_reg[14] ? (intreq_reg & intena_reg[13:0]) : 14'd0;

    always_comb begin
        level = 3'd0;
        if (act[13])
            level = 3'd6;
        else if (|act[12:11])
            level = 3'd5;
        else if (|act[10:7])
            level = 3'd4;
        else if (|act[6:4])
            level = 3'd3;
        else if (act[3])
            level = 3'd2;
        else if (|act[2:0])
            level = 3'd1;
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                intena_reg <= 15'd0;
                intreq_reg <= 14'd0;
                int2_reg   <= 1'b0;
                int6_reg   <= 1'b0;
                ipl_reg    <= 3'b111;
            end else begin
                intena_reg <= intena_next;
                intreq_reg <= intreq_next;
                int2_reg   <= int2;
                int6_reg   <= int6;
                ipl_reg    <= ~level;
            end
        end
    end

    assign _ipl = ipl_reg;

    always_comb begin
        data_out = 16'h0000;
        if (!wr) begin
            case (reg_address_in)
                INTENAR_ADDR: data_out = {1'b0, intena_reg};
                INTREQR_ADDR: data_out = {2'b00, intreq_reg};
                default:      data_out = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: a bit-level reference model checked every
// cycle, plus literal expectations at key points of the sequence.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        clk7_en = 1'b1;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        txint = 0, rxint = 0, vblint = 0, blckint = 0, syncint = 0, int3 = 0;
    logic [3:0]  audint = 4'h0;
    logic        int2 = 0, int6 = 0;
    logic [2:0]  ipl;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    irq_arbiter dut (
        .clk(clk), .clk7_en(clk7_en), .reset(reset), .wr(wr),
        .reg_address_in(addr), .data_in(data_in), .data_out(data_out),
        .txint(txint), .rxint(rxint), .vblint(vblint), .blckint(blckint),
        .syncint(syncint), .int3(int3), .audint(audint),
        .int2(int2), .int6(int6), ._ipl(ipl)
    );

    always #5 clk = ~clk;

    // Reference model: plain bit vectors and a per-bit priority table.
    int          lvl_tab [0:13] = '{1, 1, 1, 2, 3, 3, 3, 4, 4, 4, 4, 5, 5, 6};
    logic [14:0] m_ena = '0;
    logic [13:0] m_req = '0;
    logic        m_p2 = 0, m_p6 = 0;
    logic [2:0]  m_ipl = 3'b111;

    function automatic int level_of(input logic [13:0] req, input logic [14:0] ena);
        int lv;
        lv = 0;
        if (ena[14])
            for (int i = 0; i < 14; i++)
                if (req[i] && ena[i] && lvl_tab[i] > lv) lv = lvl_tab[i];
        return lv;
    endfunction

    always @(posedge clk) begin : model
        logic [14:0] e;
        logic [13:0] r, hw;
        if (clk7_en) begin
            if (reset) begin
                m_ena <= '0; m_req <= '0; m_p2 <= 0; m_p6 <= 0; m_ipl <= 3'b111;
            end else begin
                e = m_ena;
                r = m_req;
                if (wr && addr == 8'h4D) e = data_in[15] ? (e | data_in[14:0]) : (e & ~data_in[14:0]);
                if (wr && addr == 8'h4E) r = data_in[15] ? (r | data_in[13:0]) : (r & ~data_in[13:0]);
                hw = '0;
                hw[0] = txint; hw[3] = int2 & ~m_p2; hw[4] = int3; hw[5] = vblint;
                hw[6] = blckint; hw[10:7] = audint; hw[11] = rxint; hw[12] = syncint;
                hw[13] = int6 & ~m_p6;
                m_ena <= e;
                m_req <= r | hw;
                m_p2  <= int2;
                m_p6  <= int6;
                m_ipl <= ~3'(level_of(m_req, m_ena));
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] exp_do;
        if (chk_en) begin
            exp_do = 16'h0000;
            if (!wr && addr == 8'h0E) exp_do = {1'b0, m_ena};
            if (!wr && addr == 8'h0F) exp_do = {2'b00, m_req};
            n_vec++;
            if (ipl !== m_ipl) begin
                n_err++;
                $display("FAIL model_ipl t=%0t: got %b expected %b", $time, ipl, m_ipl);
            end
            n_vec++;
            if (data_out !== exp_do) begin
                n_err++;
                $display("FAIL model_data_out t=%0t addr=%h: got %h expected %h", $time, addr, data_out, exp_do);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s = %h", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [15:0] d);
        wr = 1'b1; addr = a; data_in = d;
        tick();
        wr = 1'b0; data_in = 16'h0000;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [15:0] exp);
        wr = 1'b0; addr = a;
        #1;
        chk(name, data_out, exp);
    endtask

    task automatic chk_ipl(input string name, input logic [2:0] exp);
        chk(name, {13'd0, ipl}, {13'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        chk_ipl("reset_ipl", 3'b111);
        rd("reset_intenar", 8'h0E, 16'h0000);
        rd("reset_intreqr", 8'h0F, 16'h0000);

        // Vertical blank request with master enable.
        wr_reg(8'h4D, 16'hC020);
        rd("intenar_c020", 8'h0E, 16'h4020);
        vblint = 1; tick(); vblint = 0;
        rd("vbl_intreqr", 8'h0F, 16'h0020);
        chk_ipl("vbl_ipl_latency", 3'b111);
        tick();
        chk_ipl("vbl_ipl", 3'b100);
        wr_reg(8'h4E, 16'h0020);
        wr_reg(8'h4D, 16'h7FFF);
        tick();

        // CIA edges: int2 and int6 rise together and stay high.
        wr_reg(8'h4D, 16'hE008);
        int2 = 1; int6 = 1; tick();
        tick();
        chk_ipl("cia_level6", 3'b001);
        wr_reg(8'h4E, 16'h2000);
        tick();
        chk_ipl("cia_level2", 3'b101);
        wr_reg(8'h4E, 16'h0008);
        tick();
        rd("cia_held_no_reset", 8'h0F, 16'h0000);
        chk_ipl("cia_held_ipl", 3'b111);
        int2 = 0; int6 = 0;

        // Hardware set beats software clear.
        wr_reg(8'h4D, 16'h8040);
        blckint = 1; wr_reg(8'h4E, 16'h0040); blckint = 0;
        rd("hw_wins", 8'h0F, 16'h0040);
        tick();
        chk_ipl("blk_ipl", 3'b100);

        // Master enable gating, then priority walk-down.
        wr_reg(8'h4D, 16'h7FFF);
        wr_reg(8'h4E, 16'hFFFF);
        wr_reg(8'h4D, 16'hBFFF);
        tick();
        rd("all_req", 8'h0F, 16'h3FFF);
        rd("all_ena", 8'h0E, 16'h3FFF);
        chk_ipl("master_off", 3'b111);
        wr_reg(8'h4D, 16'hC000);
        chk_ipl("master_on_latency", 3'b111);
        tick();
        chk_ipl("master_on", 3'b001);
        wr_reg(8'h4E, 16'h2000); tick();
        chk_ipl("level5", 3'b010);
        wr_reg(8'h4E, 16'h1800); tick();
        chk_ipl("level4", 3'b011);

        // Reset beats a simultaneous write.
        reset = 1; wr_reg(8'h4D, 16'h4010); reset = 0;
        chk_ipl("reset_mid_ipl", 3'b111);
        rd("reset_mid_ena", 8'h0E, 16'h0000);
        rd("reset_mid_req", 8'h0F, 16'h0000);

        // Clock enable low freezes everything.
        clk7_en = 0; txint = 1;
        wr_reg(8'h4E, 16'h8001); tick();
        txint = 0;
        rd("hold_req", 8'h0F, 16'h0000);
        chk_ipl("hold_ipl", 3'b111);
        clk7_en = 1;
        wr_reg(8'h4D, 16'hC001);
        txint = 1; tick(); txint = 0;
        tick();
        chk_ipl("tx_level1", 3'b110);
        clk7_en = 0;
        wr_reg(8'h4D, 16'h4000); tick();
        chk_ipl("hold_ipl_nonzero", 3'b110);
        rd("hold_ena", 8'h0E, 16'h4001);
        clk7_en = 1;

        // Unmapped addresses.
        wr_reg(8'h4F, 16'hFFFF); tick();
        rd("unmapped_wr", 8'h0E, 16'h4001);
        rd("unmapped_rd", 8'h4D, 16'h0000);

        // Audio channel 2 -> bit 9, level 4 above level 1.
        wr_reg(8'h4D, 16'hC200);
        audint = 4'b0100; tick(); audint = 4'h0;
        tick();
        rd("aud_req", 8'h0F, 16'h0201);
        chk_ipl("aud_level4", 3'b011);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
